mem_port_arbiter: RTL and testbench

Arbitrates the single shared memory port between the instruction-fetch requester and the data (load/store) requester of the 5-stage MIPS pipeline. It runs the downstream variable-latency req/ack handshake, generates byte enables and replicated write data for byte stores, and sign- or zero-extends byte loads. It sits between the fetch and memory stages and the memory interface. Its done pulses gate pipeline advance.

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared memory port arbiter for fetch and load/store requesters
// Optional bus timeout: define MEM_PORT_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_byte,
    input  logic        d_signext,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state, state_next;
    logic        owner_d;
    logic [3:0]  starve_cnt;
    logic        byte_ld;
    logic        signext;
    logic [1:0]  byte_off;
    logic        grant_any;
    logic        grant_d;
    logic        timeout;
    logic [31:0] ack_data;
    logic [31:0] ld_data;
    logic [7:0]  sel_byte;

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    logic [31:0] to_cnt;

    assign timeout = (state == ISSUE) && !mem_ack && (to_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt  <= '0;
            bus_err <= 1'b0;
        end else begin
            to_cnt <= (state == ISSUE) ? to_cnt + 32'd1 : '0;
            if (timeout) begin
                bus_err <= 1'b1;
            end
        end
    end
`else
    assign timeout = (TIMEOUT_CYCLES < 0);
    assign bus_err = 1'b0;
`endif

    // Data wins ties until fetch has been passed over STARVE_LIMIT times in a row.
    always_comb begin
        grant_any = if_req | d_req;
        grant_d   = d_req & (~if_req | (starve_cnt != LIMIT));
    end

    always_comb begin
        ack_data = timeout ? 32'hDEADBEEF : mem_rdata;
        sel_byte = mem_rdata[{byte_off, 3'b000} +: 8];
        ld_data  = ack_data;
        if (byte_ld && !timeout) begin
            ld_data = {{24{signext & sel_byte[7]}}, sel_byte};
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_any) state_next = ISSUE;
            ISSUE:   if (mem_ack || timeout) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_d    <= 1'b0;
            starve_cnt <= '0;
            byte_ld    <= 1'b0;
            signext    <= 1'b0;
            byte_off   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_done    <= 1'b0;
            d_done     <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner_d <= grant_d;
                        mem_req <= 1'b1;
                        if (grant_d) begin
                            mem_we    <= d_we;
                            mem_addr  <= {d_addr[31:2], 2'b00};
                            mem_be    <= (d_byte && d_we) ? (4'b0001 << d_addr[1:0]) : 4'b1111;
                            mem_wdata <= d_byte ? {4{d_wdata[7:0]}} : d_wdata;
                            byte_ld   <= d_byte & ~d_we;
                            signext   <= d_signext;
                            byte_off  <= d_addr[1:0];
                            if (if_req && (starve_cnt != LIMIT)) begin
                                starve_cnt <= starve_cnt + 4'd1;
                            end
                        end else begin
                            mem_we     <= 1'b0;
                            mem_addr   <= {if_addr[31:2], 2'b00};
                            mem_be     <= 4'b1111;
                            mem_wdata  <= '0;
                            byte_ld    <= 1'b0;
                            starve_cnt <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ack || timeout) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (owner_d) begin
                            d_done  <= 1'b1;
                            d_rdata <= ld_data;
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= ack_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_done, d_req, d_we, d_byte, d_signext, d_done;
    logic        mem_req, mem_we, mem_ack, bus_err;
    logic [3:0]  mem_be;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_signext(d_signext),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          chk;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    bit          grant_log[$];
    logic [31:0] mem_model[logic [29:0]];
    int          checks = 0;
    int          errors = 0;
    bit          sb_en = 0;
    int          ack_dly_max = 0;
    int          m_starve = 0;

    logic        s_if_req, s_d_req, s_d_we, s_d_byte, s_d_sx;
    logic [31:0] s_if_addr, s_d_addr, s_d_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_word(input logic [29:0] w);
        if (!mem_model.exists(w)) mem_model[w] = $urandom;
        return mem_model[w];
    endfunction

    // Requests as the DUT sampled them on the latest rising edge.
    always @(posedge clk) begin
        s_if_req  = if_req;
        s_if_addr = if_addr;
        s_d_req   = d_req;
        s_d_we    = d_we;
        s_d_byte  = d_byte;
        s_d_sx    = d_signext;
        s_d_addr  = d_addr;
        s_d_wdata = d_wdata;
    end

    // Memory responder and grant model.
    initial begin
        logic        prev;
        bit          g_d, we_, by_, sx_;
        logic [31:0] a, wd, word, r;
        logic [3:0]  be;
        logic [1:0]  off;
        exp_t        e;
        int          dly;
        prev = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (sb_en && mem_req && !prev) begin
                if (!s_if_req && !s_d_req) check("spurious_grant", 32'd1, 32'd0);
                g_d = s_d_req && (!s_if_req || m_starve != STARVE_LIMIT);
                if (g_d) begin
                    if (s_if_req) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT;
                end else begin
                    m_starve = 0;
                end
                grant_log.push_back(g_d);
                we_ = g_d && s_d_we;
                by_ = s_d_byte;
                sx_ = s_d_sx;
                wd  = s_d_wdata;
                a   = g_d ? s_d_addr : s_if_addr;
                off = a[1:0];
                be  = (we_ && by_) ? (4'b0001 << off) : 4'hF;
                check("mem_addr", mem_addr, {a[31:2], 2'b00});
                check("mem_we", {31'b0, mem_we}, {31'b0, we_});
                check("mem_be", {28'b0, mem_be}, {28'b0, be});
                if (we_) check("mem_wdata", mem_wdata, by_ ? {4{wd[7:0]}} : wd);
                dly = $urandom_range(ack_dly_max, 0);
                repeat (dly) begin
                    @(negedge clk);
                    check("mem_req_hold", {31'b0, mem_req}, 32'd1);
                end
                word = get_word(a[31:2]);
                e.is_d = g_d;
                e.chk  = !we_;
                if (we_) begin
                    for (int i = 0; i < 4; i++)
                        if (be[i]) word[8*i +: 8] = by_ ? wd[7:0] : wd[8*i +: 8];
                    mem_model[a[31:2]] = word;
                    e.rdata = '0;
                    mem_rdata = $urandom;
                end else begin
                    if (g_d && by_) begin
                        r = (word >> (8 * off)) & 32'hFF;
                        if (sx_ && r[7]) r = r | 32'hFFFFFF00;
                        e.rdata = r;
                    end else begin
                        e.rdata = word;
                    end
                    mem_rdata = word;
                end
                mem_ack = 1'b1;
                exp_q.push_back(e);
                @(negedge clk);
                mem_ack = 1'b0;
                check("mem_req_drop", {31'b0, mem_req}, 32'd0);
            end
            prev = mem_req;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb_en && (if_done || d_done)) begin
            check("done_one_hot", {31'b0, if_done & d_done}, 32'd0);
            if (exp_q.size() == 0) begin
                check("done_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_owner", {31'b0, d_done}, {31'b0, e.is_d});
                if (e.chk) check(e.is_d ? "d_rdata" : "if_rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
            end
        end
    end

    task automatic fetch_op(input logic [31:0] a, input bit keep, output int lat);
        if_addr = a;
        if_req  = 1'b1;
        lat = 0;
        forever begin
            @(posedge clk); #1;
            lat++;
            if (if_done) break;
            if (lat > 300) begin
                check("if_done_timeout", 32'd1, 32'd0);
                break;
            end
        end
        if (!keep) if_req = 1'b0;
    endtask

    task automatic data_op(input bit we, input bit by, input bit sx, input logic [31:0] a,
                           input logic [31:0] wd, input bit keep, output int lat);
        d_we = we; d_byte = by; d_signext = sx; d_addr = a; d_wdata = wd;
        d_req = 1'b1;
        lat = 0;
        forever begin
            @(posedge clk); #1;
            lat++;
            if (d_done) break;
            if (lat > 300) begin
                check("d_done_timeout", 32'd1, 32'd0);
                break;
            end
        end
        if (!keep) d_req = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat, l1, l2, l3, l4;
        bit  seen;
        rst = 1'b1;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_byte = 0; d_signext = 0;
        d_addr = 0; d_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_be", {28'b0, mem_be}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_dones", {30'b0, if_done, d_done}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_bus_err", {31'b0, bus_err}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset while an access is in ISSUE.
        if_addr = 32'h00400100;
        if_req = 1'b1;
        for (int i = 0; i < 10 && !mem_req; i++) begin
            @(posedge clk); #1;
        end
        check("rst_test_issue", {31'b0, mem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mid_if_done", {31'b0, if_done}, 32'd0);
        @(negedge clk);
        if_req = 1'b0;
        rst = 1'b0;
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (if_done) seen = 1;
        end
        check("no_done_after_rst", {31'b0, seen}, 32'd0);

        sb_en = 1;
        ack_dly_max = 0;
        mem_model[30'(32'h00400004 >> 2)] = 32'h8C820000;
        fetch_op(32'h00400004, 0, lat);
        check("fetch_latency", lat, 32'd2);
        check("fetch_rdata", if_rdata, 32'h8C820000);

        grant_log.delete();
        fork
            fetch_op(32'h00400010, 0, l1);
            data_op(0, 0, 0, 32'h10010000, 32'h0, 0, l2);
        join
        check("tie_count", grant_log.size(), 32'd2);
        if (grant_log.size() == 2) begin
            check("tie_first_d", {31'b0, grant_log[0]}, 32'd1);
            check("tie_then_i", {31'b0, grant_log[1]}, 32'd0);
        end

        data_op(1, 1, 0, 32'h10010003, 32'h000000A5, 0, lat);

        mem_model[30'(32'h10010008 >> 2)] = 32'h80123456;
        data_op(0, 1, 1, 32'h1001000B, 32'h0, 0, lat);
        check("lb_off3", d_rdata, 32'hFFFFFF80);
        data_op(0, 1, 0, 32'h1001000B, 32'h0, 0, lat);
        check("lbu_off3", d_rdata, 32'h00000080);
        data_op(0, 0, 0, 32'h1001000B, 32'h0, 0, lat);
        check("lw_off3", d_rdata, 32'h80123456);

        // Both requesters held continuously from a fresh reset.
        @(negedge clk);
        rst = 1'b1;
        m_starve = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        grant_log.delete();
        fork
            begin
                for (int i = 0; i < 2; i++) fetch_op(32'h00400020 + 8 * i, i == 0, l3);
            end
            begin
                for (int i = 0; i < 6; i++) data_op(0, 0, 0, 32'h10010010 + 4 * i, 32'h0, i < 5, l4);
            end
        join
        if (grant_log.size() < 5) begin
            check("starve_count", grant_log.size(), 32'd5);
        end else begin
            for (int i = 0; i < 5; i++) check("starve_grant", {31'b0, grant_log[i]}, (i < 4) ? 32'd1 : 32'd0);
        end

        ack_dly_max = 3;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int g;
                    g = $urandom_range(3, 0);
                    fetch_op(32'h00400000 | ($urandom & 32'h3FF), (g == 0) && (i != 39), l3);
                    repeat (g) begin
                        @(posedge clk); #1;
                    end
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    int g;
                    g = $urandom_range(3, 0);
                    data_op(1'($urandom), 1'($urandom), 1'($urandom), 32'h10010000 + ($urandom % 64),
                            $urandom, (g == 0) && (i != 59), l4);
                    repeat (g) begin
                        @(posedge clk); #1;
                    end
                end
            end
        join
        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
